// File: rtl/pwm_pkg.sv
// pwm_pkg - shared types and defaults for the PWM link blocks.
//   pwm_state_e        : demodulator frame-tracking states
//   PWM_WIDTH          : default level width (frame = 2**PWM_WIDTH clocks)
//   PWM_TIMEOUT_FRAMES : default stuck-detection window, in frames
//   maj3()             : 3-input majority, used by the optional glitch filter
package pwm_pkg;

   typedef enum logic [1:0] {
      SEEK    = 2'd0,
      MEASURE = 2'd1,
      STUCK_S = 2'd2
   } pwm_state_e;

   localparam int PWM_WIDTH          = 8;
   localparam int PWM_TIMEOUT_FRAMES = 2;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/pwm_input_sync.sv
// pwm_input_sync - input conditioning for the PWM demodulator.
//   CLK, RST : clock, synchronous active-high reset
//   PWM_IN   : asynchronous PWM line
//   s        : synchronised (optionally filtered) level
//   rise     : one-cycle strobe, s went 0 -> 1
// Build option: PWM_DEMOD_GLITCH_FILTER_EN adds a 3-tap majority filter after
// the 2-flop synchroniser (latency 4 instead of 2, single-cycle glitches removed).
module pwm_input_sync
   import pwm_pkg::*;
(
   input  logic CLK,
   input  logic RST,
   input  logic PWM_IN,
   output logic s,
   output logic rise
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic s_d_q, s_d_d;

`ifdef PWM_DEMOD_GLITCH_FILTER_EN
   logic tap1_q, tap1_d;
   logic tap2_q, tap2_d;
   logic filt_q, filt_d;

   always_comb begin
      tap1_d = sync2_q;
      tap2_d = tap1_q;
      filt_d = maj3(sync2_q, tap1_q, tap2_q);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         tap1_q <= 1'b0;
         tap2_q <= 1'b0;
         filt_q <= 1'b0;
      end else begin
         tap1_q <= tap1_d;
         tap2_q <= tap2_d;
         filt_q <= filt_d;
      end
   end

   assign s = filt_q;
`else
   assign s = sync2_q;
`endif

   always_comb begin
      sync1_d = PWM_IN;
      sync2_d = sync1_q;
      s_d_d   = s;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         s_d_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         s_d_q   <= s_d_d;
      end
   end

   assign rise = s & ~s_d_q;

endmodule

// File: rtl/pwm_demodulator.sv
// pwm_demodulator - recovers the duty level of a fixed-frame PWM stream.
//   WIDTH          : level width, frame length PERIOD = 2**WIDTH clocks
//   TIMEOUT_FRAMES : frames without a rising edge before STUCK is raised
//   CLK, RST       : clock, synchronous active-high reset
//   PWM_IN         : asynchronous PWM input
//   LEVEL          : last recovered level (registered)
//   VALID          : one-cycle pulse when LEVEL is written
//   STUCK          : input has shown no rising edge for TIMEOUT clocks
//   PERIOD_ERR     : one-cycle pulse, a completed frame was not PERIOD long
// Build option: PWM_DEMOD_GLITCH_FILTER_EN (see pwm_input_sync).
module pwm_demodulator
   import pwm_pkg::*;
#(
   parameter int WIDTH          = PWM_WIDTH,
   parameter int TIMEOUT_FRAMES = PWM_TIMEOUT_FRAMES
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             PWM_IN,
   output logic [WIDTH-1:0] LEVEL,
   output logic             VALID,
   output logic             STUCK,
   output logic             PERIOD_ERR
);

   localparam int PERIOD  = 2**WIDTH;
   localparam int TIMEOUT = TIMEOUT_FRAMES * PERIOD;
   localparam int CW      = $clog2(TIMEOUT + 1);

   localparam logic [CW-1:0] PERIOD_C  = CW'(PERIOD);
   localparam logic [CW-1:0] TO_C      = CW'(TIMEOUT);
   localparam logic [CW-1:0] TO_M1_C   = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] ONE_C     = CW'(1);

   logic s, rise;

   pwm_input_sync u_sync (
      .CLK    (CLK),
      .RST    (RST),
      .PWM_IN (PWM_IN),
      .s      (s),
      .rise   (rise)
   );

   pwm_state_e       state_q, state_d;
   logic [CW-1:0]    p_q, p_d;
   logic [CW-1:0]    h_q, h_d;
   logic [WIDTH-1:0] level_q, level_d;
   logic             valid_q, valid_d;
   logic             stuck_q, stuck_d;
   logic             perr_q, perr_d;

   logic [CW-1:0]    p_inc, h_inc;

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      h_d     = h_q;
      level_d = level_q;
      valid_d = 1'b0;
      stuck_d = stuck_q;
      perr_d  = 1'b0;

      // Counters saturate so a dead line can never wrap back into range.
      p_inc = (p_q == TO_C) ? p_q : p_q + ONE_C;
      h_inc = (s && (h_q != TO_C)) ? h_q + ONE_C : h_q;

      case (state_q)
         SEEK: begin
            if (rise) begin
               state_d = MEASURE;
               p_d     = ONE_C;
               h_d     = ONE_C;
            end else if (p_q == TO_M1_C) begin
               state_d = STUCK_S;
               stuck_d = 1'b1;
               level_d = {WIDTH{s}};
               valid_d = 1'b1;
            end else begin
               p_d = p_inc;
            end
         end
         MEASURE: begin
            // Rise closes the frame and also starts the next one; the rise
            // cycle itself is high, hence p = h = 1.
            if (rise) begin
               if (p_q == PERIOD_C) begin
                  level_d = h_q[WIDTH-1:0];
                  valid_d = 1'b1;
               end else begin
                  perr_d = 1'b1;
               end
               p_d = ONE_C;
               h_d = ONE_C;
            end else if (p_q == TO_M1_C) begin
               state_d = STUCK_S;
               stuck_d = 1'b1;
               level_d = {WIDTH{s}};
               valid_d = 1'b1;
            end else begin
               p_d = p_inc;
               h_d = h_inc;
            end
         end
         STUCK_S: begin
            // The frame following recovery is only opened, never reported.
            if (rise) begin
               state_d = MEASURE;
               p_d     = ONE_C;
               h_d     = ONE_C;
               stuck_d = 1'b0;
            end
         end
         default: state_d = SEEK;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= SEEK;
         p_q     <= '0;
         h_q     <= '0;
         level_q <= '0;
         valid_q <= 1'b0;
         stuck_q <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         h_q     <= h_d;
         level_q <= level_d;
         valid_q <= valid_d;
         stuck_q <= stuck_d;
         perr_q  <= perr_d;
      end
   end

   assign LEVEL      = level_q;
   assign VALID      = valid_q;
   assign STUCK      = stuck_q;
   assign PERIOD_ERR = perr_q;

endmodule

// File: tb/tb_pwm_demodulator.sv
// tb_pwm_demodulator - directed bench for pwm_demodulator (WIDTH=8, TIMEOUT=512).
module tb_pwm_demodulator;

   logic       CLK = 1'b0;
   logic       RST;
   logic       PWM_IN;
   logic [7:0] LEVEL;
   logic       VALID, STUCK, PERIOD_ERR;

   pwm_demodulator dut (
      .CLK        (CLK),
      .RST        (RST),
      .PWM_IN     (PWM_IN),
      .LEVEL      (LEVEL),
      .VALID      (VALID),
      .STUCK      (STUCK),
      .PERIOD_ERR (PERIOD_ERR)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;

   // Pulse monitor, sampled mid-cycle.
   int cyc = 0, n_valid = 0, n_perr = 0, last_v = 0, prev_v = 0;
   always @(negedge CLK) begin
      cyc = cyc + 1;
      if (VALID) begin
         n_valid = n_valid + 1;
         prev_v  = last_v;
         last_v  = cyc;
      end
      if (PERIOD_ERR) n_perr = n_perr + 1;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // One PWM frame: high for hi clocks (except an optional one-clock dropout).
   task automatic frame(input int len, input int hi, input int glitch_at);
      for (int i = 0; i < len; i++) begin
         PWM_IN = (i < hi) && (i != glitch_at);
         tick(1);
      end
   endtask

   task automatic run(input int lvl, input int n);
      repeat (n) frame(256, lvl, -1);
   endtask

   int v0, e0;

   task automatic snap();
      v0 = n_valid;
      e0 = n_perr;
   endtask

   initial begin
      PWM_IN = 1'b0;
      RST    = 1'b1;
      tick(3);
      chk("rst_level", LEVEL, 0);
      chk("rst_valid", VALID, 0);
      chk("rst_stuck", STUCK, 0);
      chk("rst_perr",  PERIOD_ERR, 0);

      // Constant low from reset: STUCK at exactly 512 clocks.
      RST = 1'b0;
      tick(511);
      chk("stuck_511", STUCK, 0);
      tick(1);
      chk("stuck_512", STUCK, 1);
      chk("stuck_valid", VALID, 1);
      chk("stuck_level", LEVEL, 0);
      tick(1);
      chk("stuck_valid_once", VALID, 0);

      // Recovery at level 10: first rise only opens a frame.
      snap();
      run(10, 3);
      chk("l10_stuck", STUCK, 0);
      chk("l10_level", LEVEL, 10);
      chk("l10_nvalid", n_valid - v0, 2);
      chk("l10_nperr", n_perr - e0, 0);

      snap();
      run(85, 4);
      chk("l85_level", LEVEL, 85);
      chk("l85_nvalid", n_valid - v0, 4);
      chk("l85_gap", last_v - prev_v, 256);
      chk("l85_nperr", n_perr - e0, 0);
      chk("l85_stuck", STUCK, 0);

      snap();
      run(255, 3);
      chk("l255_level", LEVEL, 255);
      chk("l255_nvalid", n_valid - v0, 3);
      chk("l255_nperr", n_perr - e0, 0);

      // Ramp: LEVEL lags one frame behind.
      snap();
      for (int k = 1; k <= 8; k++) begin
         frame(256, k, -1);
         chk($sformatf("ramp_%0d", k), LEVEL, (k == 1) ? 255 : k - 1);
      end
      chk("ramp_nvalid", n_valid - v0, 8);
      chk("ramp_nperr", n_perr - e0, 0);

      // 200-clock frames: the 256 ramp frame closes normally, then errors.
      snap();
      repeat (4) frame(200, 50, -1);
      chk("per_nvalid", n_valid - v0, 1);
      chk("per_nperr", n_perr - e0, 3);
      chk("per_level", LEVEL, 8);

      run(128, 2);
      chk("l128_level", LEVEL, 128);
      snap();
      frame(256, 128, 60);
      frame(256, 128, -1);
`ifdef PWM_DEMOD_GLITCH_FILTER_EN
      chk("glitch_nvalid", n_valid - v0, 2);
      chk("glitch_nperr", n_perr - e0, 0);
`else
      chk("glitch_nvalid", n_valid - v0, 1);
      chk("glitch_nperr", n_perr - e0, 2);
`endif
      chk("glitch_level", LEVEL, 128);

      // Reset during the low phase of a frame.
      frame(200, 128, -1);
      PWM_IN = 1'b0;
      RST    = 1'b1;
      tick(1);
      chk("mrst_level", LEVEL, 0);
      chk("mrst_valid", VALID, 0);
      chk("mrst_stuck", STUCK, 0);
      chk("mrst_perr",  PERIOD_ERR, 0);
      RST = 1'b0;
      snap();
      run(77, 1);
      chk("mrst_first", n_valid - v0, 0);
      run(77, 1);
      chk("mrst_second", n_valid - v0, 1);
      chk("mrst_level77", LEVEL, 77);

      // Line stuck high: last 77 frame closes, then STUCK with full level.
      snap();
      PWM_IN = 1'b1;
      tick(600);
      chk("hi_stuck", STUCK, 1);
      chk("hi_level", LEVEL, 255);
      chk("hi_nvalid", n_valid - v0, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
